smpl_capture: RTL and testbench

Capture controller directly downstream of the channel sampler. Consumes the 8-bit `smpl` word, which packs four sample times of CH_H/CH_L, and writes it into a circular sample RAM. It tracks pre-trigger fill, arms the trigger, counts post-trigger samples and freezes the buffer. When frozen it reports the oldest-sample address for readout.

---
 rtl/smpl_capture_if.sv | 36 +++
 rtl/smpl_capture.sv | 133 +++++++++++++
 tb/tb_smpl_capture.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/smpl_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : smpl_capture_if
// Description : Capture-controller bus: sampler/trigger inputs, RAM write port
//               and capture status.
// Revision    : 1.0
// ============================================================================
interface smpl_capture_if #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
);
    logic          run;
    logic          wrt_smpl;
    logic [7:0]    smpl;
    logic          triggered;
    logic [AW:0]   trig_pos;
    logic          clr_done;
    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          armed;
    logic          capturing;
    logic          capture_done;
    logic [AW-1:0] start_addr;

    modport master (
        output run, wrt_smpl, smpl, triggered, trig_pos, clr_done,
        input  we, waddr, wdata, armed, capturing, capture_done, start_addr
    );

    modport slave (
        input  run, wrt_smpl, smpl, triggered, trig_pos, clr_done,
        output we, waddr, wdata, armed, capturing, capture_done, start_addr
    );
endinterface
`default_nettype wire

// File: rtl/smpl_capture.sv
`default_nettype none
// ============================================================================
// Module      : smpl_capture
// Description : Circular sample-RAM capture controller: pre-trigger fill,
//               trigger arming, post-trigger count and buffer freeze.
// Revision    : 1.0
// ============================================================================
module smpl_capture #(
    parameter  int DEPTH = 512,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    smpl_capture_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_POST = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [AW-1:0] start_addr_q, start_addr_d;
    logic [AW:0]   pre_cnt_q, pre_cnt_d;
    logic [AW:0]   post_cnt_q, post_cnt_d;
    logic          armed_q, armed_d;

    logic [AW:0]   w_tp_eff;
    logic [AW:0]   w_pre_need;
    logic [AW:0]   w_pre_cnt_inc;
    logic [AW:0]   w_post_cnt_inc;
    logic [AW-1:0] w_waddr_inc;
    logic          w_capturing;
    logic          w_we;

    always_comb begin
        w_tp_eff       = (bus.trig_pos > C_DEPTH) ? C_DEPTH : bus.trig_pos;
        w_pre_need     = C_DEPTH - w_tp_eff;
        w_capturing    = (state_q == S_RUN) || (state_q == S_POST);
        w_we           = bus.wrt_smpl & w_capturing;
        w_waddr_inc    = waddr_q + AW'(1);
        // Pre-trigger count saturates at DEPTH so long pre-fills cannot wrap.
        w_pre_cnt_inc  = (w_we && (pre_cnt_q != C_DEPTH)) ? pre_cnt_q + (AW+1)'(1) : pre_cnt_q;
        w_post_cnt_inc = post_cnt_q + (AW+1)'(1);

        state_d      = state_q;
        waddr_d      = w_we ? w_waddr_inc : waddr_q;
        start_addr_d = start_addr_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        armed_d      = armed_q;

        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_d    = S_RUN;
                    waddr_d    = '0;
                    pre_cnt_d  = '0;
                    post_cnt_d = '0;
                    armed_d    = (w_pre_need == '0);
                end
            end
            S_RUN: begin
                pre_cnt_d = w_pre_cnt_inc;
                if (w_pre_cnt_inc >= w_pre_need) begin
                    armed_d = 1'b1;
                end
                // Only the registered armed flag qualifies the trigger, so
                // arming and triggering on one edge does not start POST.
                if (bus.triggered && armed_q) begin
                    if (w_tp_eff == '0) begin
                        state_d      = S_DONE;
                        start_addr_d = waddr_d;
                        armed_d      = 1'b0;
                    end else begin
                        state_d = S_POST;
                    end
                end
            end
            S_POST: begin
                if (w_we) begin
                    post_cnt_d = w_post_cnt_inc;
                    if (w_post_cnt_inc == w_tp_eff) begin
                        state_d      = S_DONE;
                        start_addr_d = w_waddr_inc;
                        armed_d      = 1'b0;
                    end
                end
            end
            S_DONE: begin
                if (bus.clr_done) begin
                    state_d = S_IDLE;
                    armed_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                armed_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            waddr_q      <= '0;
            start_addr_q <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            start_addr_q <= start_addr_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            armed_q      <= armed_d;
        end
    end

    assign bus.we           = w_we;
    assign bus.waddr        = waddr_q;
    assign bus.wdata        = bus.smpl;
    assign bus.armed        = armed_q;
    assign bus.capturing    = w_capturing;
    assign bus.capture_done = (state_q == S_DONE);
    assign bus.start_addr   = start_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_smpl_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_smpl_capture
// Description : Directed self-checking bench for smpl_capture with DEPTH = 8.
// Revision    : 1.0
// ============================================================================
module tb_smpl_capture;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    smpl_capture_if #(.DEPTH(DEPTH)) bus ();

    smpl_capture #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          run;
        logic          wrt;
        logic [7:0]    smpl;
        logic          trig;
        logic          clr;
        logic          we;
        logic [AW-1:0] waddr;
        logic          armed;
        logic          cap;
        logic          done;
        logic [AW-1:0] start;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic r, w, input logic [7:0] s, input logic t, c,
                                input logic e_we, input logic [AW-1:0] e_wa,
                                input logic e_arm, e_cap, e_done, input logic [AW-1:0] e_st);
        vec_t v;
        v.run = r; v.wrt = w; v.smpl = s; v.trig = t; v.clr = c;
        v.we = e_we; v.waddr = e_wa; v.armed = e_arm; v.cap = e_cap;
        v.done = e_done; v.start = e_st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, w, input logic [7:0] s, input logic t, c);
        bus.run       = r;
        bus.wrt_smpl  = w;
        bus.smpl      = s;
        bus.triggered = t;
        bus.clr_done  = c;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [AW:0] tp);
        rst          = 1'b1;
        bus.trig_pos = tp;
        drive(0, 0, 8'h00, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    // {we, waddr, armed, capturing, capture_done, start_addr}
    function automatic logic [31:0] outs();
        return {22'd0, bus.we, bus.waddr, bus.armed, bus.capturing, bus.capture_done, bus.start_addr};
    endfunction

    initial begin
        // Test 1 + handshake: trig_pos = 3, writes every cycle, trigger at write 7
        tbl[0]  = mk(1, 1, 8'hAA, 0, 0,  0, 3'd0, 0, 0, 0, 3'd0);
        tbl[1]  = mk(0, 1, 8'h00, 0, 0,  1, 3'd0, 0, 1, 0, 3'd0);
        tbl[2]  = mk(0, 1, 8'h01, 0, 0,  1, 3'd1, 0, 1, 0, 3'd0);
        tbl[3]  = mk(0, 1, 8'h02, 0, 0,  1, 3'd2, 0, 1, 0, 3'd0);
        tbl[4]  = mk(0, 1, 8'h03, 0, 0,  1, 3'd3, 0, 1, 0, 3'd0);
        tbl[5]  = mk(0, 1, 8'h04, 0, 0,  1, 3'd4, 0, 1, 0, 3'd0);
        tbl[6]  = mk(0, 1, 8'h05, 0, 0,  1, 3'd5, 1, 1, 0, 3'd0);
        tbl[7]  = mk(0, 1, 8'h06, 1, 0,  1, 3'd6, 1, 1, 0, 3'd0);
        tbl[8]  = mk(0, 1, 8'h07, 0, 0,  1, 3'd7, 1, 1, 0, 3'd0);
        tbl[9]  = mk(0, 1, 8'h08, 0, 0,  1, 3'd0, 1, 1, 0, 3'd0);
        tbl[10] = mk(0, 1, 8'h09, 0, 0,  1, 3'd1, 1, 1, 0, 3'd0);
        tbl[11] = mk(0, 1, 8'h0A, 0, 0,  0, 3'd2, 0, 0, 1, 3'd2);
        tbl[12] = mk(1, 1, 8'h0B, 0, 0,  0, 3'd2, 0, 0, 1, 3'd2);
        tbl[13] = mk(0, 0, 8'h0C, 0, 1,  0, 3'd2, 0, 0, 1, 3'd2);
        tbl[14] = mk(0, 0, 8'h0D, 0, 0,  0, 3'd2, 0, 0, 0, 3'd2);
        tbl[15] = mk(1, 0, 8'h0E, 0, 0,  0, 3'd2, 0, 0, 0, 3'd2);
        tbl[16] = mk(0, 0, 8'h0F, 0, 0,  0, 3'd0, 0, 1, 0, 3'd2);

        rst          = 1'b1;
        bus.trig_pos = 4'd3;
        drive(0, 0, 8'h00, 0, 0);
        #1;
        check("reset_outputs", outs(), 32'd0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].run, tbl[i].wrt, tbl[i].smpl, tbl[i].trig, tbl[i].clr);
            #4;
            check($sformatf("vec%0d", i), outs(),
                  {22'd0, tbl[i].we, tbl[i].waddr, tbl[i].armed, tbl[i].cap, tbl[i].done, tbl[i].start});
            check($sformatf("vec%0d_wdata", i), {24'd0, bus.wdata}, {24'd0, tbl[i].smpl});
            @(posedge clk);
            #1;
        end

        // Test 2: trigger held from run, trig_pos = 2, accepted only once armed
        do_reset(4'd2);
        drive(1, 0, 8'h00, 1, 0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 8'(i), 1, 0); tick();
        end
        check("t2_unarmed_after5", {31'd0, bus.armed}, 32'd0);
        drive(0, 1, 8'h05, 1, 0); tick();
        check("t2_armed_after6", {31'd0, bus.armed}, 32'd1);
        drive(0, 0, 8'h00, 1, 0); tick();
        drive(0, 1, 8'h06, 1, 0); tick();
        check("t2_not_done_after7", {31'd0, bus.capture_done}, 32'd0);
        drive(0, 1, 8'h07, 1, 0); tick();
        check("t2_done_after8", {31'd0, bus.capture_done}, 32'd1);
        check("t2_start_addr", {29'd0, bus.start_addr}, 32'd0);
        drive(0, 1, 8'h08, 0, 0); #1;
        check("t2_no_write_in_done", {31'd0, bus.we}, 32'd0);
        tick();

        // Test 3: trig_pos = 0, RUN goes straight to DONE
        do_reset(4'd0);
        drive(1, 0, 8'h00, 0, 0); tick();
        for (int i = 0; i < 7; i++) begin
            drive(0, 1, 8'(i), 0, 0); tick();
        end
        check("t3_unarmed_after7", {31'd0, bus.armed}, 32'd0);
        drive(0, 1, 8'h07, 0, 0); tick();
        check("t3_armed_after8", {31'd0, bus.armed}, 32'd1);
        drive(0, 1, 8'h08, 0, 0); tick();
        drive(0, 0, 8'h00, 1, 0); tick();
        check("t3_done", {31'd0, bus.capture_done}, 32'd1);
        check("t3_start_eq_waddr", {29'd0, bus.start_addr}, 32'd1);
        check("t3_waddr_hold", {29'd0, bus.waddr}, 32'd1);

        // Test 4: trig_pos = 9 clamps to DEPTH
        do_reset(4'd9);
        drive(1, 0, 8'h00, 0, 0); tick();
        check("t4_armed_after_run", {31'd0, bus.armed}, 32'd1);
        drive(0, 1, 8'h50, 1, 0); tick();
        for (int i = 0; i < 7; i++) begin
            drive(0, 1, 8'(i), 0, 0); tick();
        end
        check("t4_not_done_after7", {31'd0, bus.capture_done}, 32'd0);
        drive(0, 1, 8'h57, 0, 0); tick();
        check("t4_done_after8", {31'd0, bus.capture_done}, 32'd1);
        check("t4_start_addr", {29'd0, bus.start_addr}, 32'd1);

        // Test 6: asynchronous reset mid-POST
        do_reset(4'd3);
        drive(1, 0, 8'h00, 0, 0); tick();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 8'(i), 0, 0); tick();
        end
        drive(0, 1, 8'h06, 1, 0); tick();
        drive(0, 1, 8'h07, 0, 0); tick();
        check("t6_capturing_pre", {31'd0, bus.capturing}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_reset", outs(), 32'd0);
        tick();
        rst = 1'b0;
        drive(1, 0, 8'h00, 0, 0); tick();
        drive(0, 0, 8'h00, 0, 0);
        check("t6_idle_then_run", {31'd0, bus.capturing}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
